// File: rtl/buffet_credit_filler_if.sv
// buffet_credit_filler_if: source stream, buffet push and credit-return signals of the filler
interface buffet_credit_filler_if #(
   parameter int DATA_WIDTH = 32,
   parameter int IDX_WIDTH  = 8,
   parameter int SIZE       = 256
);
   localparam int CNT_W = $clog2(SIZE + 1);
   logic [DATA_WIDTH-1:0] src_data;
   logic                  src_valid;
   logic                  src_ready;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  push_data_valid;
   logic                  push_data_ready;
   logic [IDX_WIDTH-1:0]  credit_in;
   logic                  credit_in_valid;
   logic                  credit_in_ready;
   logic [CNT_W-1:0]      credits_o;
   logic                  credit_ovf_o;
   modport master (
      input  src_data, src_valid, push_data_ready, credit_in, credit_in_valid,
      output src_ready, push_data, push_data_valid, credit_in_ready, credits_o, credit_ovf_o
   );
   modport slave (
      output src_data, src_valid, push_data_ready, credit_in, credit_in_valid,
      input  src_ready, push_data, push_data_valid, credit_in_ready, credits_o, credit_ovf_o
   );
endinterface

// File: rtl/buffet_credit_filler.sv
// buffet_credit_filler: credit-gated producer that never pushes more words than the buffet can hold
module buffet_credit_filler #(
   parameter int DATA_WIDTH = 32,
   parameter int IDX_WIDTH  = 8,
   parameter int SIZE       = 256,
   localparam int CNT_W     = $clog2(SIZE + 1)
) (
   input  logic                   clk,
   input  logic                   reset_i,
   buffet_credit_filler_if.master bus
);
   // sum is wide enough for SIZE plus the largest credit return, so overflow is always visible
   localparam int SUM_W = ((CNT_W > IDX_WIDTH) ? CNT_W : IDX_WIDTH) + 1;
   localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);
   localparam logic [SUM_W-1:0] SIZE_S = SUM_W'(SIZE);

   typedef enum logic [1:0] {INIT, RUN, NOCRED} state_t;

   state_t                r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_pdata;
   logic                  r_pvalid;
   logic                  r_ovf;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic [SUM_W-1:0]      w_sum;
   logic                  w_crdy, w_credit, w_src_ready, w_accept, w_ovf_nxt;

   // handshakes, credit arithmetic and next state; returned credits only reach src_ready through r_cnt
   always_comb begin
      w_crdy      = r_state != INIT;
      w_credit    = bus.credit_in_valid & w_crdy;
      w_src_ready = (r_state == RUN) & (!r_pvalid | bus.push_data_ready);
      w_accept    = bus.src_valid & w_src_ready;
      w_sum       = SUM_W'(r_cnt) + (w_credit ? SUM_W'(bus.credit_in) : '0) - SUM_W'(w_accept);
      w_ovf_nxt   = w_sum > SIZE_S;
      w_cnt_nxt   = (r_state == INIT || w_ovf_nxt) ? SIZE_C : w_sum[CNT_W-1:0];
      w_state_nxt = (r_state != INIT && w_cnt_nxt == '0) ? NOCRED : RUN;
   end

   // state register; INIT holds for one cycle after reset so no word is taken before the counter is loaded
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) r_state <= INIT;
      else         r_state <= w_state_nxt;
   end

   // single output register: load on accept, drop valid once the buffet takes the word
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         r_pdata  <= '0;
         r_pvalid <= 1'b0;
      end else if (w_accept) begin
         r_pdata  <= bus.src_data;
         r_pvalid <= 1'b1;
      end else if (bus.push_data_ready) begin
         r_pvalid <= 1'b0;
      end
   end

   // credit counter with saturation at SIZE and a sticky over-return flag
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         r_cnt <= SIZE_C;
         r_ovf <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_ovf <= r_ovf | (w_crdy & w_ovf_nxt);
      end
   end

   assign bus.src_ready       = w_src_ready;
   assign bus.push_data       = r_pdata;
   assign bus.push_data_valid = r_pvalid;
   assign bus.credit_in_ready = w_crdy;
   assign bus.credits_o       = r_cnt;
   assign bus.credit_ovf_o    = r_ovf;
endmodule
